// File: rtl/servo_pwm_decodificador.sv
// Servo PWM monitor: synchronises a PWM line, measures the high time and the
// period of every frame and classifies it as parado / horario / anti-horario.
module servo_pwm_decodificador #(
    parameter int W           = 21,
    parameter int PERIODO     = 1_000_000,
    parameter int TOL_PERIODO = 50_000,
    parameter int L_HORARIO   = 50_000,
    parameter int L_PARADO    = 75_000,
    parameter int L_ANTI      = 100_000,
    parameter int TOL_LARGURA = 2_500,
    parameter int TIMEOUT     = 1_250_000
) (
    input  logic         i_clock,
    input  logic         i_reset,
    input  logic         i_habilita,
    input  logic         i_pwm,
    output logic [W-1:0] o_largura,
    output logic [W-1:0] o_periodo,
    output logic [1:0]   o_direcao,
    output logic         o_valido,
    output logic         o_erro,
    output logic [2:0]   o_db_estado
);

    localparam logic [W-1:0] C_PERIODO   = W'(PERIODO);
    localparam logic [W-1:0] C_TOL_PER   = W'(TOL_PERIODO);
    localparam logic [W-1:0] C_L_HORARIO = W'(L_HORARIO);
    localparam logic [W-1:0] C_L_PARADO  = W'(L_PARADO);
    localparam logic [W-1:0] C_L_ANTI    = W'(L_ANTI);
    localparam logic [W-1:0] C_TOL_LARG  = W'(TOL_LARGURA);
    localparam logic [W-1:0] C_TIMEOUT   = W'(TIMEOUT);
    localparam logic [W-1:0] C_UM        = W'(1);
    localparam logic [W-1:0] C_MAX       = '1;

    localparam logic [1:0] DIR_PARADO   = 2'b00;
    localparam logic [1:0] DIR_HORARIO  = 2'b01;
    localparam logic [1:0] DIR_ANTI     = 2'b10;
    localparam logic [1:0] DIR_INVALIDO = 2'b11;

    typedef enum logic [2:0] {
        S_INICIAL = 3'd0,
        S_ESPERA  = 3'd1,
        S_ALTO    = 3'd2,
        S_BAIXO   = 3'd3,
        S_AVALIA  = 3'd4,
        S_FALHA   = 3'd5
    } estado_t;

    estado_t      r_estado;
    estado_t      w_estado_prox;

    logic         r_pwm_p0;
    logic         r_pwm_p1;
    logic         r_pwm_p2;
    logic         w_subida;

    logic [W-1:0] r_cnt_alto;
    logic [W-1:0] r_cnt_per;
    logic         w_timeout;

    logic         w_carrega;
    logic         w_captura;
    logic         w_falha;
    logic         w_conta;
    logic         w_limpa;

    // Absolute difference without wrap: compare first, then subtract the smaller.
    function automatic logic [W-1:0] f_absdiff(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [W-1:0] f_inc_sat(input logic [W-1:0] v);
        return (v == C_MAX) ? v : (v + C_UM);
    endfunction

    // Returns {erro, direcao}; exactly one width window must match a good period.
    function automatic logic [2:0] f_classifica(input logic [W-1:0] larg, input logic [W-1:0] per);
        logic       per_ok;
        logic       m_h;
        logic       m_p;
        logic       m_a;
        logic [2:0] res;
        per_ok = (f_absdiff(per, C_PERIODO) <= C_TOL_PER);
        m_h    = (f_absdiff(larg, C_L_HORARIO) <= C_TOL_LARG);
        m_p    = (f_absdiff(larg, C_L_PARADO) <= C_TOL_LARG);
        m_a    = (f_absdiff(larg, C_L_ANTI) <= C_TOL_LARG);
        res    = {1'b1, DIR_INVALIDO};
        if (per_ok) begin
            case ({m_h, m_p, m_a})
                3'b100:  res = {1'b0, DIR_HORARIO};
                3'b010:  res = {1'b0, DIR_PARADO};
                3'b001:  res = {1'b0, DIR_ANTI};
                default: res = {1'b1, DIR_INVALIDO};
            endcase
        end
        return res;
    endfunction

    // Stage p0/p1: synchroniser; stage p2: one-cycle delay for edge detection.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_pwm_p0 <= 1'b0;
            r_pwm_p1 <= 1'b0;
            r_pwm_p2 <= 1'b0;
        end else begin
            r_pwm_p0 <= i_pwm;
            r_pwm_p1 <= r_pwm_p0;
            r_pwm_p2 <= r_pwm_p1;
        end
    end

    assign w_subida  = r_pwm_p1 & ~r_pwm_p2;
    assign w_timeout = (r_cnt_per == C_TIMEOUT);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_estado <= S_INICIAL;
        end else begin
            r_estado <= w_estado_prox;
        end
    end

    always_comb begin
        w_estado_prox = r_estado;
        if (!i_habilita) begin
            w_estado_prox = S_INICIAL;
        end else begin
            case (r_estado)
                S_INICIAL: w_estado_prox = S_ESPERA;
                S_ESPERA:  if (w_subida) w_estado_prox = S_ALTO;
                S_ALTO: begin
                    if (w_timeout)      w_estado_prox = S_FALHA;
                    else if (!r_pwm_p1) w_estado_prox = S_BAIXO;
                end
                S_BAIXO: begin
                    if (w_timeout)     w_estado_prox = S_FALHA;
                    else if (w_subida) w_estado_prox = S_AVALIA;
                end
                S_AVALIA:  w_estado_prox = r_pwm_p1 ? S_ALTO : S_BAIXO;
                S_FALHA:   if (!r_pwm_p1) w_estado_prox = S_ESPERA;
                default:   w_estado_prox = S_INICIAL;
            endcase
        end
    end

    always_comb begin
        w_carrega = 1'b0;
        w_captura = 1'b0;
        w_falha   = 1'b0;
        w_conta   = 1'b0;
        w_limpa   = 1'b0;
        if (!i_habilita) begin
            w_limpa = 1'b1;
        end else begin
            case (r_estado)
                S_INICIAL: w_limpa = 1'b1;
                S_ESPERA:  w_carrega = w_subida;
                S_ALTO: begin
                    w_conta = 1'b1;
                    w_falha = w_timeout;
                end
                S_BAIXO: begin
                    w_conta   = 1'b1;
                    w_falha   = w_timeout;
                    w_captura = w_subida & ~w_timeout;
                    w_carrega = w_subida & ~w_timeout;
                end
                S_AVALIA:  w_conta = 1'b1;
                S_FALHA:   w_limpa = 1'b1;
                default:   w_limpa = 1'b1;
            endcase
        end
    end

    // The rising edge that closes a frame also opens the next one, hence the reload to 1.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_cnt_alto <= '0;
            r_cnt_per  <= '0;
        end else if (w_carrega) begin
            r_cnt_alto <= C_UM;
            r_cnt_per  <= C_UM;
        end else if (w_conta) begin
            r_cnt_per <= f_inc_sat(r_cnt_per);
            if (r_pwm_p1) begin
                r_cnt_alto <= f_inc_sat(r_cnt_alto);
            end
        end else if (w_limpa) begin
            r_cnt_alto <= '0;
            r_cnt_per  <= '0;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_largura <= '0;
            o_periodo <= '0;
            o_direcao <= DIR_PARADO;
            o_erro    <= 1'b0;
            o_valido  <= 1'b0;
        end else begin
            o_valido <= w_captura;
            if (w_captura) begin
                o_largura             <= r_cnt_alto;
                o_periodo             <= r_cnt_per;
                {o_erro, o_direcao}   <= f_classifica(r_cnt_alto, r_cnt_per);
            end else if (w_falha) begin
                o_erro    <= 1'b1;
                o_direcao <= DIR_INVALIDO;
            end
        end
    end

    assign o_db_estado = r_estado;

endmodule

// File: tb/tb_servo_pwm_decodificador.sv
// Directed bench for servo_pwm_decodificador with time constants scaled by 1/1000.
module tb_servo_pwm_decodificador;

    localparam int W           = 12;
    localparam int PERIODO     = 1000;
    localparam int TOL_PERIODO = 50;
    localparam int L_HORARIO   = 50;
    localparam int L_PARADO    = 75;
    localparam int L_ANTI      = 100;
    localparam int TOL_LARGURA = 3;
    localparam int TIMEOUT     = 1250;
    localparam int NV          = 14;

    typedef struct {
        int alto;
        int per;
        int dir;
        int erro;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         hab;
    logic         pwm;
    logic [W-1:0] largura;
    logic [W-1:0] periodo;
    logic [1:0]   direcao;
    logic         valido;
    logic         erro;
    logic [2:0]   db;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;
    int cap_larg [64];
    int cap_per  [64];
    int cap_dir  [64];
    int cap_erro [64];

    vec_t vt [NV];

    always #5 clk = ~clk;

    servo_pwm_decodificador #(
        .W(W), .PERIODO(PERIODO), .TOL_PERIODO(TOL_PERIODO),
        .L_HORARIO(L_HORARIO), .L_PARADO(L_PARADO), .L_ANTI(L_ANTI),
        .TOL_LARGURA(TOL_LARGURA), .TIMEOUT(TIMEOUT)
    ) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .i_habilita (hab),
        .i_pwm      (pwm),
        .o_largura  (largura),
        .o_periodo  (periodo),
        .o_direcao  (direcao),
        .o_valido   (valido),
        .o_erro     (erro),
        .o_db_estado(db)
    );

    // Records every valido pulse, sampled just after the active edge.
    always @(posedge clk) begin
        #1;
        if (valido === 1'b1) begin
            if (n_valid < 64) begin
                cap_larg[n_valid] = int'(largura);
                cap_per[n_valid]  = int'(periodo);
                cap_dir[n_valid]  = int'(direcao);
                cap_erro[n_valid] = int'(erro);
            end
            n_valid++;
        end
    end

    initial begin
        #(60000 * 10);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a falling edge; leaves pwm low at the falling edge ending the period.
    task automatic send_frame(input int h, input int p);
        pwm = 1'b1;
        repeat (h) @(negedge clk);
        pwm = 1'b0;
        repeat (p - h) @(negedge clk);
    endtask

    initial begin
        int n0;
        int n1;

        vt[0]  = '{75,  1000, 0, 0};
        vt[1]  = '{75,  1000, 0, 0};
        vt[2]  = '{50,  1000, 1, 0};
        vt[3]  = '{100, 1000, 2, 0};
        vt[4]  = '{62,  1000, 3, 1};
        vt[5]  = '{75,  750,  3, 1};
        vt[6]  = '{75,  1000, 0, 0};
        vt[7]  = '{53,  1000, 1, 0};
        vt[8]  = '{54,  1000, 3, 1};
        vt[9]  = '{75,  1050, 0, 0};
        vt[10] = '{75,  1051, 3, 1};
        vt[11] = '{97,  950,  2, 0};
        vt[12] = '{75,  949,  3, 1};
        vt[13] = '{72,  1000, 0, 0};

        rst = 1'b1;
        hab = 1'b0;
        pwm = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset largura", 32'(largura), 0);
        chk("reset periodo", 32'(periodo), 0);
        chk("reset direcao", 32'(direcao), 0);
        chk("reset valido", 32'(valido), 0);
        chk("reset erro", 32'(erro), 0);
        chk("reset estado", 32'(db), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("inicial sem habilita", 32'(db), 0);
        hab = 1'b1;
        repeat (2) @(negedge clk);
        chk("espera estado", 32'(db), 1);

        // Frame i is reported at the start of frame i+1; one trailing frame closes the last.
        n0 = n_valid;
        for (int i = 0; i < NV; i++) send_frame(vt[i].alto, vt[i].per);
        send_frame(75, 1000);
        chk("tabela contagem valido", n_valid - n0, NV);
        for (int i = 0; i < NV; i++) begin
            chk($sformatf("v%0d largura", i), cap_larg[n0 + i], vt[i].alto);
            chk($sformatf("v%0d periodo", i), cap_per[n0 + i], vt[i].per);
            chk($sformatf("v%0d direcao", i), cap_dir[n0 + i], vt[i].dir);
            chk($sformatf("v%0d erro", i), cap_erro[n0 + i], vt[i].erro);
        end

        // Latency: valido on the third active edge after the rising input.
        pwm = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("latencia valido cedo", 32'(valido), 0);
        @(posedge clk);
        #1 chk("latencia valido", 32'(valido), 1);
        chk("latencia estado avalia", 32'(db), 4);
        chk("latencia largura", 32'(largura), 75);
        chk("latencia periodo", 32'(periodo), 1000);
        @(posedge clk);
        #1 chk("valido um ciclo", 32'(valido), 0);
        chk("estado alto apos avalia", 32'(db), 2);
        @(negedge clk);
        repeat (75 - 4) @(negedge clk);
        pwm = 1'b0;
        repeat (20) @(negedge clk);
        hab = 1'b0;
        repeat (2) @(negedge clk);
        hab = 1'b1;
        repeat (2) @(negedge clk);
        chk("espera antes timeout", 32'(db), 1);

        // Stuck-high line: FALHA exactly when cnt_per reaches TIMEOUT.
        n1 = n_valid;
        pwm = 1'b1;
        repeat (TIMEOUT + 2) @(posedge clk);
        #1 chk("timeout ainda alto", 32'(db), 2);
        chk("timeout erro antes", 32'(erro), 0);
        @(posedge clk);
        #1 chk("timeout estado falha", 32'(db), 5);
        chk("timeout erro", 32'(erro), 1);
        chk("timeout direcao", 32'(direcao), 3);
        chk("timeout valido", 32'(valido), 0);
        @(negedge clk);
        repeat (40) @(negedge clk);
        pwm = 1'b0;
        repeat (5) @(negedge clk);
        chk("falha para espera", 32'(db), 1);
        chk("timeout sem valido", n_valid - n1, 0);
        send_frame(75, 1000);
        chk("erro mantido", 32'(erro), 1);
        chk("primeiro quadro sem valido", n_valid - n1, 0);
        send_frame(50, 1000);
        chk("recuperacao valido", n_valid - n1, 1);
        chk("recuperacao erro", 32'(erro), 0);
        chk("recuperacao direcao", 32'(direcao), 0);
        pwm = 1'b1;
        repeat (6) @(negedge clk);
        chk("recuperacao segundo valido", n_valid - n1, 2);
        chk("recuperacao horario", 32'(direcao), 1);
        chk("recuperacao largura", 32'(largura), 50);

        // habilita low mid-frame: FSM idles, outputs keep their values.
        hab = 1'b0;
        repeat (2) @(negedge clk);
        chk("habilita0 estado", 32'(db), 0);
        chk("habilita0 largura mantida", 32'(largura), 50);
        chk("habilita0 direcao mantida", 32'(direcao), 1);
        chk("habilita0 valido", 32'(valido), 0);
        hab = 1'b1;
        repeat (3) @(negedge clk);
        chk("habilita1 linha alta espera", 32'(db), 1);

        // Asynchronous reset in the middle of ALTO clears outputs before the next edge.
        pwm = 1'b0;
        repeat (5) @(negedge clk);
        pwm = 1'b1;
        repeat (10) @(negedge clk);
        chk("pre reset estado alto", 32'(db), 2);
        chk("pre reset largura", 32'(largura), 50);
        #2 rst = 1'b1;
        #1;
        chk("reset async largura", 32'(largura), 0);
        chk("reset async periodo", 32'(periodo), 0);
        chk("reset async direcao", 32'(direcao), 0);
        chk("reset async erro", 32'(erro), 0);
        chk("reset async valido", 32'(valido), 0);
        chk("reset async estado", 32'(db), 0);
        hab = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("pos reset habilita0 estado", 32'(db), 0);
        chk("pos reset largura", 32'(largura), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
